seg7_scan: RTL and testbench
============================

# seg7_scan

Four-digit multiplexed seven-segment driver that consumes the 8-bit result bus produced by the board's output selector stage (the mux choosing between operands, opcode and ALU result). Shows the value as unsigned decimal (leading-zero blanked) or as two hex digits. Conversion runs in a sequential double-dabble converter. A prescaled refresh counter scans the active-low anodes of the board display.

## Interface
- REFRESH_DIV, default 50000: clk cycles each digit stays lit; legal range 2..2^20.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- value  in  8  result bus from the selector stage; unsigned.
- hexMode  in  1  0 = decimal display, 1 = hex display.
- an  out  4  digit anodes, active-low; an[0] is the rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- busy  out  1  high while a conversion is in progress.

## Operation
- **Change detection.** Registers lastVal (8 bits) and lastMode hold the most recently committed inputs.
  - In IDLE, if {value, hexMode} differs from {lastVal, lastMode}, both are captured into the converter and lastVal/lastMode.
  - The FSM then enters CONV.
- **FSM states.**
  - IDLE: wait for an input change.
  - CONV: exactly 8 cycles. Each cycle first adds 3 to every BCD nibble that is ≥5, then shifts {bcd[11:0], bin[7:0]} left by 1.
  - DONE: 1 cycle; commits the result to the display buffer; then IDLE.
- **busy** is high in CONV and DONE.
- **Inputs during conversion.** Changes to value or hexMode during CONV/DONE are ignored. A mismatch still present on return to IDLE starts a new conversion.
- **Display buffer, decimal mode.**
  - digit3 = blank.
  - digit2 = hundreds; blank if 0.
  - digit1 = tens; blank if hundreds and tens are both 0.
  - digit0 = ones; always shown.
  - dp off on all digits.
- **Display buffer, hex mode.**
  - digit3 and digit2 = blank.
  - digit1 = value[7:4]; digit0 = value[3:0]; no leading-zero blanking.
  - dp lit on digit0 only.
- **Segment encoding** is active-low gfedcba. Examples: 0 = 1000000, 1 = 1111001, 8 = 0000000, F = 0001110, blank = 1111111.
- **Scan.**
  - refCnt counts 0..REFRESH_DIV-1. On wrap to 0, the digit index idx advances 0→1→2→3→0.
  - an = ~(4'b0001 << idx). seg and dp come from buffer[idx].

## Timing
- **Reset values:** an = 1111, seg = 1111111, dp = 1, busy = 0.
- **Reset internal state:** idx = 0, refCnt = 0, lastVal = 0, lastMode = 0, FSM = IDLE, buffer = decimal "0" (digit0 = 0, others blank).
- **Outputs are registered.** On the first cycle after rst is released, an = 1110 and seg shows digit0 of the buffer.
- **Conversion latency.** With a change present in IDLE at cycle N:
  - capture at edge N.
  - CONV spans N+1..N+8.
  - DONE at N+9.
  - new buffer is visible on seg from cycle N+10 (when idx selects that digit).
- **Rescan.** Every digit is refreshed every 4·REFRESH_DIV cycles. A buffer commit takes effect at the next digit visible; no frame sync.
- **Reset mid-conversion:** conversion is aborted and all state returns to reset values. The next conversion follows normally if value ≠ 0 or hexMode = 1.
- **Simultaneous events:** a commit in DONE coinciding with an idx advance shows the new buffer on the newly selected digit.

## Structure
- Package seg7_pkg holds:
  - the 16-entry hex→segment constant table and the SEG_BLANK constant;
  - the converter state enum {IDLE, CONV, DONE};
  - the localparam for digit count (4).
- Sub-module bin2bcd8 contains the double-dabble FSM.
  - Ports: clk, rst, start, bin[7:0], busy, done, bcd[11:0].
- seg7_scan contains change detection, the buffer, the refresh prescaler and the anode scan.

## Test plan
- **Reset:** hold rst 3 cycles with value = 0 → an = 1111, seg = 1111111, dp = 1, busy = 0. One cycle after release: an = 1110, seg = 1000000; busy never rises.
- **Decimal 255:** value = 255, hexMode = 0 → busy high for 9 cycles; digits 3..0 = blank, 2, 5, 5.
- **Leading-zero blanking:**
  - value = 7 → blank, blank, blank, 7.
  - value = 40 → blank, blank, 4, 0.
  - value = 100 → blank, 1, 0, 0.
- **Hex F0:** value = 8'hF0, hexMode = 1 → digits blank, blank, F (0001110), 0 (1000000). dp = 0 only while an = 1110.
- **Change mid-conversion:** value 10→200 at CONV cycle 3 → first commit shows 10; second conversion starts the cycle after DONE; final display 200; busy high 18 of 19 cycles.
- **Scan and reset abort (REFRESH_DIV = 4):**
  - Scan: an sequence 1110, 1101, 1011, 0111, 1110, each held 4 cycles.
  - Abort: assert rst during CONV → next cycle busy = 0 and the display is "0".

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed seven-segment driver.
package seg7_pkg;

  // Number of multiplexed digits on the board display.
  localparam int NUM_DIGITS = 4;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,  // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,  // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,  // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E   // C d E F
  };

  // All segments dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Double-dabble converter states.
  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } conv_state_t;

  // One display buffer entry: active-low segments plus active-low decimal point.
  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } digit_t;

  localparam digit_t DIGIT_BLANK = '{seg: SEG_BLANK, dp: 1'b1};
  localparam digit_t DIGIT_ZERO  = '{seg: 7'h40,     dp: 1'b1};

endpackage

// File: rtl/seg7_scan_bin2bcd8.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble).
// A start in IDLE loads the operand; eight CONV cycles of add-3/shift follow,
// then one DONE cycle during which bcd holds the result.
module bin2bcd8
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_t state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [19:0] shift_reg, shift_next;
  logic [19:0] adj;

  // Add-3 correction on every BCD nibble that is 5 or more, before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign adj[8 + 4*gi +: 4] = (shift_reg[8 + 4*gi +: 4] >= 4'd5)
                                  ? shift_reg[8 + 4*gi +: 4] + 4'd3
                                  : shift_reg[8 + 4*gi +: 4];
    end
  endgenerate
  assign adj[7:0] = shift_reg[7:0];

  // State, iteration counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
    end
  end

  // Next-state logic: load on start, iterate eight times, one result cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          shift_next = {12'd0, bin};
          cnt_next   = '0;
          state_next = CONV;
        end
      end
      CONV: begin
        shift_next = {adj[18:0], 1'b0};
        cnt_next   = cnt_reg + 3'd1;
        if (cnt_reg == 3'd7) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign bcd  = shift_reg[19:8];

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver for the 8-bit result bus.
// Detects input changes, converts to BCD, fills a four-entry display buffer
// and scans the active-low anodes with a prescaled refresh counter.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  input  logic       hexMode,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [7:0]  last_val_reg;
  logic        last_mode_reg;
  logic        start;
  logic        conv_busy;
  logic        conv_done;
  logic [11:0] bcd;

  logic [CNT_W-1:0] ref_cnt_reg, ref_cnt_next;
  logic [1:0]       idx_reg, idx_next;
  logic             ref_wrap;

  digit_t conv_digits [NUM_DIGITS];
  digit_t buf_reg     [NUM_DIGITS];
  digit_t buf_next    [NUM_DIGITS];
  digit_t shown;

  // A new conversion is launched only from IDLE; changes while busy wait.
  assign start = ~conv_busy && ({value, hexMode} != {last_val_reg, last_mode_reg});

  // Remember the inputs that the current conversion is working on.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_val_reg  <= '0;
      last_mode_reg <= 1'b0;
    end else if (start) begin
      last_val_reg  <= value;
      last_mode_reg <= hexMode;
    end
  end

  bin2bcd8 u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  assign busy = conv_busy;

  // Build the four buffer entries from the finished conversion and the latched mode.
  always_comb begin
    for (int d = 0; d < NUM_DIGITS; d++) begin
      conv_digits[d] = DIGIT_BLANK;
    end
    if (last_mode_reg) begin
      conv_digits[1] = '{seg: SEG_TABLE[last_val_reg[7:4]], dp: 1'b1};
      conv_digits[0] = '{seg: SEG_TABLE[last_val_reg[3:0]], dp: 1'b0};
    end else begin
      if (bcd[11:8] != 4'd0) begin
        conv_digits[2] = '{seg: SEG_TABLE[bcd[11:8]], dp: 1'b1};
      end
      if (bcd[11:4] != 8'd0) begin
        conv_digits[1] = '{seg: SEG_TABLE[bcd[7:4]], dp: 1'b1};
      end
      conv_digits[0] = '{seg: SEG_TABLE[bcd[3:0]], dp: 1'b1};
    end
  end

  // Display buffer: each digit is replaced in the DONE cycle; reset shows "0".
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_buf
      assign buf_next[gi] = conv_done ? conv_digits[gi] : buf_reg[gi];

      // Per-digit buffer register.
      always_ff @(posedge clk) begin
        if (rst) begin
          buf_reg[gi] <= (gi == 0) ? DIGIT_ZERO : DIGIT_BLANK;
        end else begin
          buf_reg[gi] <= buf_next[gi];
        end
      end
    end
  endgenerate

  // Refresh prescaler and digit index; the index steps when the counter wraps.
  assign ref_wrap     = (ref_cnt_reg == CNT_MAX);
  assign ref_cnt_next = ref_wrap ? '0 : ref_cnt_reg + CNT_W'(1);
  assign idx_next     = ref_wrap ? idx_reg + 2'd1 : idx_reg;

  // Prescaler and index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_reg <= '0;
      idx_reg     <= '0;
    end else begin
      ref_cnt_reg <= ref_cnt_next;
      idx_reg     <= idx_next;
    end
  end

  // Outputs are taken from the next buffer and next index so that a commit
  // and an index step landing on the same edge show the new data at once.
  assign shown = buf_next[idx_next];

  // Registered anode, segment and decimal-point outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << idx_next);
      seg <= shown.seg;
      dp  <= shown.dp;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with a short refresh period.
module tb_seg7_scan;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] value;
  logic       hexMode;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [6:0] frame_seg [4];
  logic       frame_dp  [4];
  int         frame_bad;

  typedef struct packed {
    logic [7:0] v;
    logic       hm;
    logic [6:0] s3;
    logic [6:0] s2;
    logic [6:0] s1;
    logic [6:0] s0;
    logic [3:0] dpn;
  } vec_t;

  vec_t vecs [8];

  seg7_scan #(.REFRESH_DIV(DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .value   (value),
    .hexMode (hexMode),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample one full scan frame and record what each digit showed.
  task automatic capture_frame();
    frame_bad = 0;
    for (int d = 0; d < 4; d++) begin
      frame_seg[d] = 7'h2A;
      frame_dp[d]  = 1'bx;
    end
    for (int k = 0; k < 4 * DIV; k++) begin
      tick();
      case (an)
        4'b1110: begin frame_seg[0] = seg; frame_dp[0] = dp; end
        4'b1101: begin frame_seg[1] = seg; frame_dp[1] = dp; end
        4'b1011: begin frame_seg[2] = seg; frame_dp[2] = dp; end
        4'b0111: begin frame_seg[3] = seg; frame_dp[3] = dp; end
        default: frame_bad++;
      endcase
    end
  endtask

  task automatic compare_frame(input string name, input logic [6:0] s3, input logic [6:0] s2,
                               input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] dpn);
    capture_frame();
    check({name, "_an_valid"}, frame_bad, 0);
    check({name, "_d3"}, frame_seg[3], s3);
    check({name, "_d2"}, frame_seg[2], s2);
    check({name, "_d1"}, frame_seg[1], s1);
    check({name, "_d0"}, frame_seg[0], s0);
    check({name, "_dp"}, {frame_dp[3], frame_dp[2], frame_dp[1], frame_dp[0]}, dpn);
    $display("frame %s: %h %h %h %h dp=%b", name, frame_seg[3], frame_seg[2],
             frame_seg[1], frame_seg[0], {frame_dp[3], frame_dp[2], frame_dp[1], frame_dp[0]});
  endtask

  // Wait for busy to drop, bounded; returns number of busy cycles observed.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int busy_hi;
    logic [3:0] prev_an;
    logic [3:0] exp_an;
    bit synced;

    vecs[0] = '{8'd255,  1'b0, 7'h7F, 7'h24, 7'h12, 7'h12, 4'b1111};
    vecs[1] = '{8'd7,    1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h78, 4'b1111};
    vecs[2] = '{8'd40,   1'b0, 7'h7F, 7'h7F, 7'h19, 7'h40, 4'b1111};
    vecs[3] = '{8'd100,  1'b0, 7'h7F, 7'h79, 7'h40, 7'h40, 4'b1111};
    vecs[4] = '{8'hF0,   1'b1, 7'h7F, 7'h7F, 7'h0E, 7'h40, 4'b1110};
    vecs[5] = '{8'h00,   1'b1, 7'h7F, 7'h7F, 7'h40, 7'h40, 4'b1110};
    vecs[6] = '{8'd205,  1'b0, 7'h7F, 7'h24, 7'h40, 7'h12, 4'b1111};
    vecs[7] = '{8'd9,    1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h10, 4'b1111};

    // Reset
    rst = 1'b1;
    value = 8'd0;
    hexMode = 1'b0;
    repeat (3) tick();
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();
    check("post_rst_an", an, 4'b1110);
    check("post_rst_seg", seg, 7'h40);
    busy_hi = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (busy) busy_hi++;
    end
    check("idle_no_busy", busy_hi, 0);

    // Table-driven conversions
    for (int i = 0; i < 8; i++) begin
      value = vecs[i].v;
      hexMode = vecs[i].hm;
      tick();
      check($sformatf("v%0d_busy_start", i), busy, 1'b1);
      count_busy(n);
      check($sformatf("v%0d_busy_len", i), n, 9);
      repeat (4 * DIV) tick();
      compare_frame($sformatf("v%0d", i), vecs[i].s3, vecs[i].s2, vecs[i].s1,
                    vecs[i].s0, vecs[i].dpn);
    end

    // Change mid-conversion, aligned to the first cycle of digit3
    synced = 1'b0;
    prev_an = an;
    for (int k = 0; k < 40 && !synced; k++) begin
      tick();
      if (an == 4'b0111 && prev_an != 4'b0111) synced = 1'b1;
      prev_an = an;
    end
    check("mid_sync", synced, 1'b1);
    value = 8'd10;
    busy_hi = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c <= 19 && busy) busy_hi++;
      if (c == 3) value = 8'd200;
      if (c == 9) begin
        check("mid_old_d1_an", an, 4'b1101);
        check("mid_old_d1_seg", seg, 7'h7F);
      end
      if (c == 10) begin
        check("mid_new_d1_an", an, 4'b1101);
        check("mid_new_d1_seg", seg, 7'h79);
        check("mid_gap_busy", busy, 1'b0);
      end
      if (c == 20) check("mid_end_busy", busy, 1'b0);
    end
    check("mid_busy_cycles", busy_hi, 18);
    repeat (4 * DIV) tick();
    compare_frame("mid_final", 7'h7F, 7'h24, 7'h40, 7'h40, 4'b1111);

    // Anode scan order and hold time
    synced = 1'b0;
    prev_an = an;
    for (int k = 0; k < 40 && !synced; k++) begin
      tick();
      if (an == 4'b1110 && prev_an != 4'b1110) synced = 1'b1;
      prev_an = an;
    end
    check("scan_sync", synced, 1'b1);
    for (int k = 0; k < 5 * DIV; k++) begin
      exp_an = ~(4'b0001 << ((k / DIV) % 4));
      check($sformatf("scan_an_%0d", k), an, exp_an);
      tick();
    end

    // Reset during conversion
    value = 8'd77;
    tick();
    tick();
    tick();
    check("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    tick();
    check("abort_busy", busy, 1'b0);
    check("abort_an", an, 4'b1111);
    check("abort_seg", seg, 7'h7F);
    rst = 1'b0;
    tick();
    check("abort_rel_an", an, 4'b1110);
    check("abort_rel_seg", seg, 7'h40);
    check("abort_rel_dp", dp, 1'b1);
    check("abort_restart_busy", busy, 1'b1);
    count_busy(n);
    check("abort_restart_len", n, 9);
    repeat (4 * DIV) tick();
    compare_frame("abort_final", 7'h7F, 7'h7F, 7'h78, 7'h78, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
